// File: rtl/ray_scheduler_pkg.sv
// Shared types for the ray scheduler: beam record, FSM state encoding and coordinate width.
package ray_scheduler_pkg;

   localparam int COORD_W = 8;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               last;
   } beam_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      FINISH
   } sched_state_t;

endpackage

// File: rtl/ray_scheduler_if.sv
// Bundles the upstream beam stream, the bresenham unit handshake and the status outputs.
interface ray_scheduler_if #(
   parameter int COUNT_W = 10
) ();

   logic                                  beam_valid;
   logic                                  beam_ready;
   logic [ray_scheduler_pkg::COORD_W-1:0] beam_x;
   logic [ray_scheduler_pkg::COORD_W-1:0] beam_y;
   logic                                  beam_last;
   logic                                  bres_start;
   logic [ray_scheduler_pkg::COORD_W-1:0] bres_x;
   logic [ray_scheduler_pkg::COORD_W-1:0] bres_y;
   logic                                  bres_busy;
   logic                                  occupancy_busy;
   logic                                  busy;
   logic                                  scan_done;
   logic [COUNT_W-1:0]                    beam_count;
   logic                                  wdog_error;

   modport master (
      input  beam_valid, beam_x, beam_y, beam_last, bres_busy, occupancy_busy,
      output beam_ready, bres_start, bres_x, bres_y, busy, scan_done, beam_count, wdog_error
   );

   modport slave (
      output beam_valid, beam_x, beam_y, beam_last, bres_busy, occupancy_busy,
      input  beam_ready, bres_start, bres_x, bres_y, busy, scan_done, beam_count, wdog_error
   );

endinterface

// File: rtl/ray_scheduler_beam_fifo.sv
// First-word-fall-through beam FIFO with registered full/empty flags.
module beam_fifo
   import ray_scheduler_pkg::*;
#(
   parameter int  DEPTH = 8,
   parameter type T     = beam_t
) (
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  T     din,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   T             mem_q [DEPTH];
   logic [AW-1:0] wrPtr_q, rdPtr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, empty_q;
   logic          doPush, doPop;

   // A pop in the same cycle frees a slot, so a full FIFO may still take a push.
   assign doPop  = pop && !empty_q;
   assign doPush = push && (!full_q || doPop);

   always_comb begin
      cnt_d = cnt_q;
      if (doPush && !doPop) begin
         cnt_d = cnt_q + (AW+1)'(1);
      end else if (!doPush && doPop) begin
         cnt_d = cnt_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
         if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == (AW+1)'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (doPush) mem_q[wrPtr_q] <= din;
   end

   assign dout  = mem_q[rdPtr_q];
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/ray_scheduler.sv
// Issues buffered LIDAR beams one at a time to the bresenham unit and flags scan completion.
// Optional watchdog on the ray handshake is enabled with SCHED_WATCHDOG_EN.
module ray_scheduler
   import ray_scheduler_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int COUNT_W    = 10,
   parameter int WDOG_CYC   = 1024
) (
   input logic             clock,
   input logic             reset,
   ray_scheduler_if.master bus
);

   sched_state_t       state_q, state_d;
   beam_t              inBeam, headBeam, cur_q;
   logic [COUNT_W-1:0] count_q;
   logic               fifoFull, fifoEmpty, push, pop;
   logic               rayDone, wdogExpired;
   logic               startOut, doneOut, busyOut;

   assign inBeam = '{x: bus.beam_x, y: bus.beam_y, last: bus.beam_last};
   assign push   = bus.beam_valid && !fifoFull;
   assign pop    = (state_q == IDLE) && !fifoEmpty && !bus.bres_busy && !bus.occupancy_busy;

   beam_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (beam_t)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (inBeam),
      .dout  (headBeam),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

`ifdef SCHED_WATCHDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYC) + 1;

   logic [WDOG_W-1:0] wdog_q;
   logic              wdogErr_q;
   logic              inWait;

   assign inWait      = (state_q == WAIT_ACK) || (state_q == WAIT_DONE);
   assign wdogExpired = inWait && (wdog_q == WDOG_W'(WDOG_CYC - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wdog_q    <= '0;
         wdogErr_q <= 1'b0;
      end else begin
         wdog_q <= (inWait && !wdogExpired) ? wdog_q + WDOG_W'(1) : '0;
         if (wdogExpired) wdogErr_q <= 1'b1;
      end
   end

   assign bus.wdog_error = wdogErr_q;
`else
   assign wdogExpired    = 1'b0;
   assign bus.wdog_error = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (pop) state_d = ISSUE;
         ISSUE:     state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (wdogExpired)        state_d = cur_q.last ? FINISH : IDLE;
            else if (bus.bres_busy) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (wdogExpired || !bus.bres_busy) state_d = cur_q.last ? FINISH : IDLE;
         end
         FINISH:    state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      startOut = 1'b0;
      doneOut  = 1'b0;
      busyOut  = (state_q != IDLE) || !fifoEmpty;
      unique case (state_q)
         ISSUE:   startOut = 1'b1;
         FINISH:  doneOut  = 1'b1;
         default: ;
      endcase
   end

   // A watchdog abandon is not a completed ray, so it never bumps the count.
   assign rayDone = (state_q == WAIT_DONE) && !bus.bres_busy && !wdogExpired;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_q   <= '0;
         count_q <= '0;
      end else begin
         if (pop) cur_q <= headBeam;
         if (state_q == FINISH)              count_q <= '0;
         else if (rayDone && !(&count_q))    count_q <= count_q + COUNT_W'(1);
      end
   end

   assign bus.beam_ready = !fifoFull;
   assign bus.bres_start = startOut;
   assign bus.bres_x     = cur_q.x;
   assign bus.bres_y     = cur_q.y;
   assign bus.busy       = busyOut;
   assign bus.scan_done  = doneOut;
   assign bus.beam_count = count_q;

endmodule

// File: tb/tb_ray_scheduler.sv
// Directed and randomized checks of ray_scheduler against a queue-based beam/scan model.
module tb_ray_scheduler;

   logic clock = 1'b0;
   logic reset;
   logic holdBusy = 1'b0;
   logic rayBusy  = 1'b0;

   always #5 clock = ~clock;

   ray_scheduler_if #(.COUNT_W(10)) busIf ();

   assign busIf.bres_busy = holdBusy | rayBusy;

   ray_scheduler #(
      .FIFO_DEPTH (8),
      .COUNT_W    (10),
      .WDOG_CYC   (16)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (busIf)
   );

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic       last;
   } refBeam_t;

   refBeam_t expQ[$];
   refBeam_t headRef;

   int checks = 0;
   int failures = 0;
   int startCount = 0;
   int doneCount = 0;
   int modelCount = 0;
   int busyLen = 5;
   int ackDelay = 0;
   int ackLeft = -1;
   int busyLeft = 0;
   int s0, d0, n;
   bit outstanding = 0, sawRise = 0, curLast = 0;
   bit checkCountNext = 0, expectDone = 0, clearNext = 0;
   bit randMode = 0, noAck = 0;

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Hold the beam on the bus until the FIFO can take it, then record it in the model.
   task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic last);
      int waited;
      waited = 0;
      busIf.beam_x     = x;
      busIf.beam_y     = y;
      busIf.beam_last  = last;
      busIf.beam_valid = 1'b1;
      while (busIf.beam_ready !== 1'b1 && waited < 300) begin
         @(negedge clock);
         waited++;
         if (waited > 4) busIf.occupancy_busy = 1'b0;
      end
      checkVal("push_accepted", 32'(busIf.beam_ready), 32'd1);
      if (busIf.beam_ready === 1'b1) expQ.push_back('{x, y, last});
      @(negedge clock);
      busIf.beam_valid = 1'b0;
   endtask

   task automatic checkOutput(input string tag);
      int cyc;
      bit drained;
      cyc = 0;
      drained = 0;
      while (!drained && cyc < 2000) begin
         @(negedge clock);
         #1;
         cyc++;
         drained = (expQ.size() == 0) && !outstanding && !checkCountNext && !clearNext &&
                   (busIf.busy === 1'b0) && (busIf.bres_busy === 1'b0);
      end
      checkVal({tag, "_drained"}, 32'(drained), 32'd1);
   endtask

   // Behavioural bresenham unit: busy rises ackDelay cycles after a start and stays up busyLen cycles.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (reset) begin
            rayBusy  = 1'b0;
            ackLeft  = -1;
            busyLeft = 0;
         end else begin
            if (ackLeft == 0) begin
               rayBusy = 1'b1;
               ackLeft = -1;
            end else if (ackLeft > 0) begin
               ackLeft--;
            end else if (rayBusy) begin
               busyLeft--;
               if (busyLeft <= 0) rayBusy = 1'b0;
            end
            if (busIf.bres_start === 1'b1 && !noAck) begin
               ackLeft  = randMode ? int'($urandom_range(0, 2)) : ackDelay;
               busyLeft = randMode ? int'($urandom_range(1, 6)) : busyLen;
            end
         end
      end
   end

   // Scoreboard: issue order, per-scan completion count and scan_done pulses.
   initial begin
      forever begin
         @(negedge clock);
         if (reset) begin
            expQ.delete();
            outstanding    = 0;
            sawRise        = 0;
            checkCountNext = 0;
            clearNext      = 0;
            modelCount     = 0;
         end else begin
            if (checkCountNext) begin
               checkVal("ray_count", 32'(busIf.beam_count), modelCount);
               checkVal("scan_done_after_ray", 32'(busIf.scan_done), 32'(expectDone));
               if (expectDone) begin
                  clearNext  = 1;
                  modelCount = 0;
               end
               checkCountNext = 0;
            end else if (clearNext) begin
               checkVal("count_cleared", 32'(busIf.beam_count), 32'd0);
               checkVal("scan_done_one_cycle", 32'(busIf.scan_done), 32'd0);
               clearNext = 0;
            end else begin
               checkVal("scan_done_idle", 32'(busIf.scan_done), 32'd0);
            end
            if (busIf.scan_done === 1'b1) doneCount++;
            if (busIf.bres_start === 1'b1) begin
               startCount++;
               checkVal("start_has_beam", 32'(expQ.size() > 0), 32'd1);
               if (expQ.size() > 0) begin
                  headRef = expQ.pop_front();
                  checkVal("bres_x", 32'(busIf.bres_x), 32'(headRef.x));
                  checkVal("bres_y", 32'(busIf.bres_y), 32'(headRef.y));
                  curLast = headRef.last;
               end
               outstanding = 1;
               sawRise     = 0;
            end else if (outstanding) begin
               if (busIf.bres_busy === 1'b1) begin
                  sawRise = 1;
               end else if (sawRise) begin
                  outstanding    = 0;
                  modelCount     = modelCount + 1;
                  checkCountNext = 1;
                  expectDone     = curLast;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      reset                = 1'b1;
      busIf.beam_valid     = 1'b0;
      busIf.beam_x         = '0;
      busIf.beam_y         = '0;
      busIf.beam_last      = 1'b0;
      busIf.occupancy_busy = 1'b0;

      // Reset state
      repeat (2) @(negedge clock);
      checkVal("rst_beam_ready", 32'(busIf.beam_ready), 32'd1);
      checkVal("rst_busy", 32'(busIf.busy), 32'd0);
      checkVal("rst_bres_start", 32'(busIf.bres_start), 32'd0);
      checkVal("rst_scan_done", 32'(busIf.scan_done), 32'd0);
      checkVal("rst_beam_count", 32'(busIf.beam_count), 32'd0);
      checkVal("rst_bres_x", 32'(busIf.bres_x), 32'd0);
      checkVal("rst_bres_y", 32'(busIf.bres_y), 32'd0);
      checkVal("rst_wdog", 32'(busIf.wdog_error), 32'd0);
      reset = 1'b0;

      // Single-beam scan with start latency
      @(negedge clock);
      s0 = startCount;
      d0 = doneCount;
      busyLen  = 5;
      ackDelay = 0;
      busIf.beam_x     = 8'h10;
      busIf.beam_y     = 8'h20;
      busIf.beam_last  = 1'b1;
      busIf.beam_valid = 1'b1;
      checkVal("t2_ready", 32'(busIf.beam_ready), 32'd1);
      expQ.push_back('{8'h10, 8'h20, 1'b1});
      @(negedge clock);
      busIf.beam_valid = 1'b0;
      checkVal("t2_lat1", 32'(busIf.bres_start), 32'd0);
      @(negedge clock);
      checkVal("t2_lat2", 32'(busIf.bres_start), 32'd1);
      checkVal("t2_x", 32'(busIf.bres_x), 32'h10);
      checkVal("t2_y", 32'(busIf.bres_y), 32'h20);
      checkOutput("t2");
      checkVal("t2_starts", startCount - s0, 32'd1);
      checkVal("t2_dones", doneCount - d0, 32'd1);

      // occupancy_busy blocks issue while sampled high
      @(negedge clock);
      s0 = startCount;
      busIf.occupancy_busy = 1'b1;
      applyStimulus(8'h33, 8'h44, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checkVal("t4_blocked", 32'(busIf.bres_start), 32'd0);
      end
      checkVal("t4_no_start", startCount - s0, 32'd0);
      busIf.occupancy_busy = 1'b0;
      @(negedge clock);
      checkVal("t4_release_start", 32'(busIf.bres_start), 32'd1);
      checkOutput("t4");

      // Burst of 10 beams against a stuck-busy unit
      @(negedge clock);
      s0 = startCount;
      d0 = doneCount;
      holdBusy = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(8'(i * 3 + 1), 8'(i * 5 + 2), 1'b0);
      checkVal("t3_full", 32'(busIf.beam_ready), 32'd0);
      busIf.beam_x     = 8'hE9;
      busIf.beam_y     = 8'h9E;
      busIf.beam_last  = 1'b0;
      busIf.beam_valid = 1'b1;
      repeat (3) @(negedge clock);
      checkVal("t3_held", 32'(busIf.beam_ready), 32'd0);
      checkVal("t3_no_start", startCount - s0, 32'd0);
      holdBusy = 1'b0;
      applyStimulus(8'hE9, 8'h9E, 1'b0);
      applyStimulus(8'hF0, 8'h0F, 1'b1);
      checkOutput("t3");
      checkVal("t3_starts", startCount - s0, 32'd10);
      checkVal("t3_dones", doneCount - d0, 32'd1);

      // Two consecutive scans of 3 and 2 beams
      @(negedge clock);
      d0 = doneCount;
      applyStimulus(8'h01, 8'h02, 1'b0);
      applyStimulus(8'h03, 8'h04, 1'b0);
      applyStimulus(8'h05, 8'h06, 1'b1);
      applyStimulus(8'h07, 8'h08, 1'b0);
      applyStimulus(8'h09, 8'h0A, 1'b1);
      checkOutput("t5");
      checkVal("t5_dones", doneCount - d0, 32'd2);

      // Reset while a ray is in WAIT_DONE with another beam queued
      @(negedge clock);
      busyLen = 20;
      applyStimulus(8'h55, 8'h66, 1'b1);
      n = 0;
      while (busIf.bres_busy !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      checkVal("t1_ray_active", 32'(busIf.bres_busy), 32'd1);
      applyStimulus(8'h77, 8'h88, 1'b1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      checkVal("t1_busy", 32'(busIf.busy), 32'd0);
      checkVal("t1_bres_start", 32'(busIf.bres_start), 32'd0);
      checkVal("t1_scan_done", 32'(busIf.scan_done), 32'd0);
      checkVal("t1_beam_ready", 32'(busIf.beam_ready), 32'd1);
      checkVal("t1_beam_count", 32'(busIf.beam_count), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      s0 = startCount;
      repeat (6) @(negedge clock);
      checkVal("t1_fifo_flushed", startCount - s0, 32'd0);
      checkVal("t1_idle", 32'(busIf.busy), 32'd0);
      busyLen = 5;

      // Randomized traffic with random ray lengths and occupancy stalls
      randMode = 1;
      d0 = doneCount;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         logic lastBit;
         lastBit = ($urandom_range(0, 3) == 0) || (i == 39);
         if (lastBit) n++;
         busIf.occupancy_busy = ($urandom_range(0, 3) == 0);
         applyStimulus(8'($urandom), 8'($urandom), lastBit);
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end
      busIf.occupancy_busy = 1'b0;
      checkOutput("rand");
      checkVal("rand_dones", doneCount - d0, n);
      randMode = 0;

`ifdef SCHED_WATCHDOG_EN
      // Unacknowledged start trips the watchdog; the next beam still issues
      @(negedge clock);
      noAck = 1;
      s0 = startCount;
      applyStimulus(8'hA1, 8'hB2, 1'b0);
      applyStimulus(8'hC3, 8'hD4, 1'b1);
      n = 0;
      while (busIf.bres_start !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      checkVal("wd_start", 32'(busIf.bres_start), 32'd1);
      repeat (16) @(negedge clock);
      checkVal("wd_not_yet", 32'(busIf.wdog_error), 32'd0);
      @(negedge clock);
      checkVal("wd_error", 32'(busIf.wdog_error), 32'd1);
      outstanding = 0;
      noAck = 0;
      checkOutput("wd");
      checkVal("wd_starts", startCount - s0, 32'd2);
      checkVal("wd_sticky", 32'(busIf.wdog_error), 32'd1);
`else
      checkVal("wdog_tied_low", 32'(busIf.wdog_error), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
